// File: rtl/studio_video_timing_if.sv
// -----------------------------------------------------------------------------
// studio_video_timing_if
// Framebuffer fetch bus between the video timing stage and display memory.
//
// Parameters
//    PIX_W : pixel intensity width
//    XW    : fetch column width
//    YW    : fetch line width
//
// Signals
//    fetch_en : fetch request valid for the current pixel (active area only)
//    fetch_x  : active-area column of the requested pixel
//    fetch_y  : active-area line of the requested pixel
//    video_in : pixel intensity returned for the previous fetch request
//
// Modports
//    master : timing generator (drives fetch, receives video_in)
//    slave  : display memory   (receives fetch, drives video_in)
// -----------------------------------------------------------------------------
interface studio_video_timing_if #(
   parameter int PIX_W = 8,
   parameter int XW    = 8,
   parameter int YW    = 8
);
   logic             fetch_en;
   logic [XW-1:0]    fetch_x;
   logic [YW-1:0]    fetch_y;
   logic [PIX_W-1:0] video_in;

   modport master (
      output fetch_en,
      output fetch_x,
      output fetch_y,
      input  video_in
   );

   modport slave (
      input  fetch_en,
      input  fetch_x,
      input  fetch_y,
      output video_in
   );
endinterface

// File: rtl/studio_video_timing.sv
// -----------------------------------------------------------------------------
// studio_video_timing
// Video timing and pixel-output stage for the Studio II core. Generates the
// pixel clock enable, horizontal/vertical counters with runtime NTSC/PAL line
// count, issues framebuffer fetch coordinates one pixel ahead of display and
// registers the returned intensity into tinted RGB aligned with sync/blank.
//
// Optional feature macro: STUDIO_VIDEO_TINT_EN
//    defined   : col selects white/red/green/blue tint
//    undefined : col is ignored, r = g = b = video_in
//
// Ports
//    clk         in   system clock
//    reset       in   synchronous active-high reset
//    pal         in   0 = NTSC line count, 1 = PAL line count (frame-latched)
//    col         in   tint select: 0 white, 1 red, 2 green, 3 blue
//    fb          --   fetch bus (master): fetch_en/x/y out, video_in in
//    ce_pix      out  one-clk pixel enable, one clk in every CE_DIV
//    frame_start out  one-clk pulse with ce_pix for pixel (0,0)
//    HSync/VSync out  active-high syncs, aligned with r/g/b
//    HBlank/VBlank out active-high blanks, aligned with r/g/b
//    r/g/b       out  tinted pixel channels
// -----------------------------------------------------------------------------
module studio_video_timing #(
   parameter int CE_DIV     = 4,
   parameter int PIX_W      = 8,
   parameter int H_ACTIVE   = 256,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 32,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 192,
   parameter int V_FP       = 24,
   parameter int V_SYNC     = 3,
   parameter int NTSC_LINES = 262,
   parameter int PAL_LINES  = 312
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pal,
   input  logic [1:0]              col,
   studio_video_timing_if.master   fb,
   output logic                    ce_pix,
   output logic                    frame_start,
   output logic                    HSync,
   output logic                    VSync,
   output logic                    HBlank,
   output logic                    VBlank,
   output logic [PIX_W-1:0]        r,
   output logic [PIX_W-1:0]        g,
   output logic [PIX_W-1:0]        b
);
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int MAX_LINES = (NTSC_LINES > PAL_LINES) ? NTSC_LINES : PAL_LINES;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int VW        = $clog2(MAX_LINES);
   localparam int DW        = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam int XW        = $clog2(H_ACTIVE);
   localparam int YW        = $clog2(V_ACTIVE);

   // Divider and pixel counters
   logic [DW-1:0]    r_div;
   logic             r_ce_pix;
   logic [HW-1:0]    r_hc;
   logic [VW-1:0]    r_vc;
   logic             r_pal_q;

   // Fetch stage
   logic             r_fetch_en;
   logic [XW-1:0]    r_fetch_x;
   logic [YW-1:0]    r_fetch_y;
   logic             r_frame_start;

   // Timing flags of the pixel currently being fetched, consumed one pixel later
   logic             r_hblank_d;
   logic             r_vblank_d;
   logic             r_hsync_d;
   logic             r_vsync_d;

   // Output stage
   logic             r_hsync;
   logic             r_vsync;
   logic             r_hblank;
   logic             r_vblank;
   logic [PIX_W-1:0] r_r;
   logic [PIX_W-1:0] r_g;
   logic [PIX_W-1:0] r_b;

   logic             w_tick;
   logic             w_last_px;
   logic             w_last_ln;
   logic [VW-1:0]    w_lines_m1;
   logic             w_hact;
   logic             w_vact;
   logic             w_hsync;
   logic             w_vsync;
   logic             w_blank_d;
   logic [PIX_W-1:0] w_rgb [3];

   // w_tick marks the clk edge that raises ce_pix; the pixel pipeline advances
   // on that same edge so fetch and output registers are valid while ce_pix is high.
   assign w_tick     = (r_div == DW'(CE_DIV - 1));
   assign w_last_px  = (r_hc == HW'(H_TOTAL - 1));
   assign w_lines_m1 = r_pal_q ? VW'(PAL_LINES - 1) : VW'(NTSC_LINES - 1);
   assign w_last_ln  = (r_vc == w_lines_m1);
   assign w_hact     = (r_hc < HW'(H_ACTIVE));
   assign w_vact     = (r_vc < VW'(V_ACTIVE));
   assign w_hsync    = (r_hc >= HW'(H_ACTIVE + H_FP)) && (r_hc < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vsync    = (r_vc >= VW'(V_ACTIVE + V_FP)) && (r_vc < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign w_blank_d  = r_hblank_d | r_vblank_d;

   // Per-channel tint: channel gi is lit for white or for its own colour code.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
`ifdef STUDIO_VIDEO_TINT_EN
         assign w_rgb[gi] = ((col == 2'd0) || (col == 2'(gi + 1))) ? fb.video_in : '0;
`else
         assign w_rgb[gi] = fb.video_in;
`endif
      end
   endgenerate

`ifndef STUDIO_VIDEO_TINT_EN
   // col is kept on the port list for drop-in compatibility but not used here.
   logic w_unused_col;
   assign w_unused_col = ^col;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div         <= '0;
         r_ce_pix      <= 1'b0;
         r_hc          <= '0;
         r_vc          <= '0;
         r_pal_q       <= pal;
         r_fetch_en    <= 1'b0;
         r_fetch_x     <= '0;
         r_fetch_y     <= '0;
         r_frame_start <= 1'b0;
         // The pixel "before" (0,0) is the last pixel of a frame: blanked, no sync.
         r_hblank_d    <= 1'b1;
         r_vblank_d    <= 1'b1;
         r_hsync_d     <= 1'b0;
         r_vsync_d     <= 1'b0;
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_r           <= '0;
         r_g           <= '0;
         r_b           <= '0;
      end else begin
         r_div         <= w_tick ? '0 : r_div + DW'(1);
         r_ce_pix      <= w_tick;
         r_fetch_en    <= 1'b0;
         r_frame_start <= 1'b0;

         if (w_tick) begin
            // Fetch stage: request the pixel at the current counters.
            r_fetch_en    <= w_hact && w_vact;
            r_frame_start <= (r_hc == '0) && (r_vc == '0);
            if (w_hact && w_vact) begin
               r_fetch_x <= r_hc[XW-1:0];
               r_fetch_y <= r_vc[YW-1:0];
            end

            // Output stage: present the pixel fetched on the previous ce_pix.
            r_hblank <= r_hblank_d;
            r_vblank <= r_vblank_d;
            r_hsync  <= r_hsync_d;
            r_vsync  <= r_vsync_d;
            r_r      <= w_blank_d ? '0 : w_rgb[0];
            r_g      <= w_blank_d ? '0 : w_rgb[1];
            r_b      <= w_blank_d ? '0 : w_rgb[2];

            r_hblank_d <= !w_hact;
            r_vblank_d <= !w_vact;
            r_hsync_d  <= w_hsync;
            r_vsync_d  <= w_vsync;

            // Counter advance; the line-count mode only changes at frame wrap.
            if (w_last_px) begin
               r_hc <= '0;
               if (w_last_ln) begin
                  r_vc    <= '0;
                  r_pal_q <= pal;
               end else begin
                  r_vc <= r_vc + VW'(1);
               end
            end else begin
               r_hc <= r_hc + HW'(1);
            end
         end
      end
   end

   assign ce_pix      = r_ce_pix;
   assign frame_start = r_frame_start;
   assign fb.fetch_en = r_fetch_en;
   assign fb.fetch_x  = r_fetch_x;
   assign fb.fetch_y  = r_fetch_y;
   assign HSync       = r_hsync;
   assign VSync       = r_vsync;
   assign HBlank      = r_hblank;
   assign VBlank      = r_vblank;
   assign r           = r_r;
   assign g           = r_g;
   assign b           = r_b;

endmodule

// File: tb/tb_studio_video_timing.sv
// -----------------------------------------------------------------------------
// tb_studio_video_timing
// Bench for studio_video_timing. Instance A uses the default geometry with
// CE_DIV=4 (pixel-level checks on the first lines, mid-line reset); instance B
// uses a reduced geometry with CE_DIV=1 (whole-frame line counts, NTSC->PAL
// switch, continuous ce_pix). Expected values are pushed into queues by the
// stimulus processes and popped by independent monitors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_studio_video_timing;
   localparam int PW   = 8;
   localparam int A_XW = 8;
   localparam int A_YW = 8;
   localparam int B_XW = 4;
   localparam int B_YW = 3;
`ifdef STUDIO_VIDEO_TINT_EN
   localparam bit TINT = 1'b1;
`else
   localparam bit TINT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT A: default geometry, CE_DIV = 4 ----------------
   logic          rst_a, pal_a;
   logic [1:0]    col_a;
   logic          ce_a, fs_a, hs_a, vs_a, hb_a, vb_a;
   logic [PW-1:0] r_a, g_a, b_a;
   studio_video_timing_if #(.PIX_W(PW), .XW(A_XW), .YW(A_YW)) fb_a ();

   studio_video_timing #(.CE_DIV(4), .PIX_W(PW)) u_dut_a (
      .clk(clk), .reset(rst_a), .pal(pal_a), .col(col_a), .fb(fb_a),
      .ce_pix(ce_a), .frame_start(fs_a), .HSync(hs_a), .VSync(vs_a),
      .HBlank(hb_a), .VBlank(vb_a), .r(r_a), .g(g_a), .b(b_a)
   );

   // ---------------- DUT B: reduced geometry, CE_DIV = 1 ----------------
   logic          rst_b, pal_b;
   logic [1:0]    col_b;
   logic          ce_b, fs_b, hs_b, vs_b, hb_b, vb_b;
   logic [PW-1:0] r_b, g_b, b_b;
   studio_video_timing_if #(.PIX_W(PW), .XW(B_XW), .YW(B_YW)) fb_b ();

   studio_video_timing #(
      .CE_DIV(1), .PIX_W(PW), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .NTSC_LINES(16), .PAL_LINES(20)
   ) u_dut_b (
      .clk(clk), .reset(rst_b), .pal(pal_b), .col(col_b), .fb(fb_b),
      .ce_pix(ce_b), .frame_start(fs_b), .HSync(hs_b), .VSync(vs_b),
      .HBlank(hb_b), .VBlank(vb_b), .r(r_b), .g(g_b), .b(b_b)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got wait bound expired, expected event", name);
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_ce"}, 32'(ce_a), 0);
      check({tag, "_fetch_en"}, 32'(fb_a.fetch_en), 0);
      check({tag, "_fetch_x"}, 32'(fb_a.fetch_x), 0);
      check({tag, "_fetch_y"}, 32'(fb_a.fetch_y), 0);
      check({tag, "_frame_start"}, 32'(fs_a), 0);
      check({tag, "_sync"}, {30'd0, hs_a, vs_a}, 0);
      check({tag, "_blank"}, {30'd0, hb_a, vb_a}, 0);
      check({tag, "_rgb"}, {8'd0, r_a, g_a, b_a}, 0);
   endtask

   // ---------------- scoreboard A (per pixel) ----------------
   typedef struct {
      int         idx;
      logic       fe;
      logic [7:0] fx;
      logic [7:0] fy;
      logic       fs;
      logic       hs;
      logic       vs;
      logic       hb;
      logic       vb;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_a_t;
   exp_a_t q_a[$];

   task automatic push_a(input int idx, input logic fe, input int fx, input int fy,
                         input logic fs, input logic hs, input logic vs, input logic hb,
                         input logic vb, input int r, input int g, input int b);
      exp_a_t e;
      e.idx = idx; e.fe = fe; e.fx = 8'(fx); e.fy = 8'(fy); e.fs = fs;
      e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
      q_a.push_back(e);
   endtask

   // Pixel index n_a counts ce_pix pulses since reset release (0 = fetch of (0,0)).
   int n_a = -1;
   initial begin
      exp_a_t e;
      forever begin
         @(negedge clk);
         if (rst_a) begin
            n_a = -1;
         end else if (ce_a) begin
            n_a++;
            if (q_a.size() > 0 && q_a[0].idx == n_a) begin
               e = q_a.pop_front();
               check($sformatf("a_px%0d_fetch_en", n_a), 32'(fb_a.fetch_en), 32'(e.fe));
               check($sformatf("a_px%0d_fetch_x", n_a), 32'(fb_a.fetch_x), 32'(e.fx));
               check($sformatf("a_px%0d_fetch_y", n_a), 32'(fb_a.fetch_y), 32'(e.fy));
               check($sformatf("a_px%0d_frame_start", n_a), 32'(fs_a), 32'(e.fs));
               check($sformatf("a_px%0d_hsync", n_a), 32'(hs_a), 32'(e.hs));
               check($sformatf("a_px%0d_vsync", n_a), 32'(vs_a), 32'(e.vs));
               check($sformatf("a_px%0d_hblank", n_a), 32'(hb_a), 32'(e.hb));
               check($sformatf("a_px%0d_vblank", n_a), 32'(vb_a), 32'(e.vb));
               check($sformatf("a_px%0d_r", n_a), 32'(r_a), 32'(e.r));
               check($sformatf("a_px%0d_g", n_a), 32'(g_a), 32'(e.g));
               check($sformatf("a_px%0d_b", n_a), 32'(b_a), 32'(e.b));
               $display("A px %0d: fetch=%0b (%0d,%0d) fs=%0b hs=%0b vs=%0b hb=%0b vb=%0b rgb=%02h/%02h/%02h",
                        n_a, fb_a.fetch_en, fb_a.fetch_x, fb_a.fetch_y, fs_a, hs_a, vs_a,
                        hb_a, vb_a, r_a, g_a, b_a);
            end
         end
      end
   end

   // ---------------- scoreboard B (per frame) ----------------
   typedef struct {
      int len;
      int vs;
      int hs;
   } exp_b_t;
   exp_b_t q_b[$];

   int frames_b  = 0;
   int len_b     = 0;
   int vs_cnt_b  = 0;
   int hs_cnt_b  = 0;
   bit started_b = 1'b0;

   initial begin
      exp_b_t e;
      forever begin
         @(negedge clk);
         if (rst_b) begin
            frames_b = 0; len_b = 0; vs_cnt_b = 0; hs_cnt_b = 0; started_b = 1'b0;
         end else if (ce_b) begin
            if (fs_b) begin
               if (started_b && q_b.size() > 0) begin
                  e = q_b.pop_front();
                  check($sformatf("b_frame%0d_len", frames_b), 32'(len_b), 32'(e.len));
                  check($sformatf("b_frame%0d_vsync_px", frames_b), 32'(vs_cnt_b), 32'(e.vs));
                  check($sformatf("b_frame%0d_hsync_px", frames_b), 32'(hs_cnt_b), 32'(e.hs));
                  $display("B frame %0d: %0d pixels (%0d lines), vsync px %0d, hsync px %0d",
                           frames_b, len_b, len_b / 28, vs_cnt_b, hs_cnt_b);
               end
               started_b = 1'b1;
               len_b = 0; vs_cnt_b = 0; hs_cnt_b = 0;
               frames_b++;
            end
            len_b++;
            vs_cnt_b += int'(vs_b);
            hs_cnt_b += int'(hs_b);
         end
      end
   end

   // ---------------- stimulus A ----------------
   bit done_a = 1'b0;

   task automatic wait_fetch_a(input int x, input int y, input int budget, input string name);
      int k = 0;
      while (!(ce_a && fb_a.fetch_en && fb_a.fetch_x == 8'(x) && fb_a.fetch_y == 8'(y))) begin
         @(negedge clk);
         k++;
         if (k > budget) begin
            fail_now(name);
            break;
         end
      end
   endtask

   task automatic wait_ce_a(input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ce_a && k < 16);
      if (!ce_a) fail_now(name);
   endtask

   initial begin
      rst_a = 1'b1; pal_a = 1'b0; col_a = 2'd0; fb_a.video_in = 8'hFF;

      // Line 0: first pixel, active edges, blank forcing, hsync window.
      push_a(0,   1, 0,   0, 1, 0, 0, 1, 1, 0, 0, 0);
      push_a(1,   1, 1,   0, 0, 0, 0, 0, 0, 'hFF, 'hFF, 'hFF);
      push_a(255, 1, 255, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF, 'hFF);
      push_a(256, 0, 255, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF, 'hFF);
      push_a(257, 0, 255, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push_a(272, 0, 255, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push_a(273, 0, 255, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      push_a(304, 0, 255, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      push_a(305, 0, 255, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push_a(352, 1, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0);
      push_a(353, 1, 1,   1, 0, 0, 0, 0, 0, 'hFF, 'hFF, 'hFF);
      // Line 7: returned data for (5,7)..(8,7) with varying tint.
      push_a(2470, 1, 6, 7, 0, 0, 0, 0, 0, 'hA5, 'hA5, 'hA5);
      push_a(2471, 1, 7, 7, 0, 0, 0, 0, 0, TINT ? 0 : 'h80, 'h80, TINT ? 0 : 'h80);
      push_a(2472, 1, 8, 7, 0, 0, 0, 0, 0, TINT ? 0 : 'h3C, TINT ? 0 : 'h3C, 'h3C);
      push_a(2473, 1, 9, 7, 0, 0, 0, 0, 0, 'h5A, TINT ? 0 : 'h5A, TINT ? 0 : 'h5A);

      repeat (5) @(negedge clk);
      check_zero_a("a_in_reset");
      rst_a = 1'b0;

      // First ce_pix on the 4th clk after release, then every 4th.
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("a_ce_clk%0d", k), 32'(ce_a), 32'((k % 4) == 0));
      end

      wait_fetch_a(5, 7, 20000, "a_wait_fetch_5_7");
      fb_a.video_in = 8'hA5; col_a = 2'd0;
      wait_ce_a("a_wait_ce_px6");
      fb_a.video_in = 8'h80; col_a = 2'd2;
      wait_ce_a("a_wait_ce_px7");
      fb_a.video_in = 8'h3C; col_a = 2'd3;
      wait_ce_a("a_wait_ce_px8");
      fb_a.video_in = 8'h5A; col_a = 2'd1;
      wait_ce_a("a_wait_ce_px9");
      fb_a.video_in = 8'hFF; col_a = 2'd0;

      // Reset in the middle of an active line.
      wait_fetch_a(150, 8, 20000, "a_wait_fetch_150_8");
      rst_a = 1'b1;
      @(negedge clk);
      check_zero_a("a_midline_reset");
      repeat (2) @(negedge clk);
      push_a(0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      push_a(1, 1, 1, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF, 'hFF);
      rst_a = 1'b0;
      for (int k = 0; k < 3; k++) wait_ce_a("a_wait_ce_after_reset");
      done_a = 1'b1;
   end

   // ---------------- stimulus B ----------------
   bit done_b = 1'b0;

   initial begin
      exp_b_t e;
      int k;
      rst_b = 1'b1; pal_b = 1'b0; col_b = 2'd0; fb_b.video_in = 8'h40;

      // NTSC frames: 16 lines x 28 px, 3 vsync lines, 4 hsync px per line.
      e.len = 16 * 28; e.vs = 3 * 28; e.hs = 16 * 4;
      q_b.push_back(e);
      q_b.push_back(e);
      // PAL frames after the deferred switch: 20 lines.
      e.len = 20 * 28; e.vs = 3 * 28; e.hs = 20 * 4;
      q_b.push_back(e);
      q_b.push_back(e);

      repeat (3) @(negedge clk);
      check("b_in_reset_ce", 32'(ce_b), 0);
      check("b_in_reset_rgb", {8'd0, r_b, g_b, b_b}, 0);
      check("b_in_reset_flags", {27'd0, fs_b, hs_b, vs_b, hb_b, vb_b}, 0);
      rst_b = 1'b0;

      // CE_DIV = 1: ce_pix high on every clk from the first clk after release.
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         check($sformatf("b_ce_clk%0d", c), 32'(ce_b), 1);
      end

      k = 0;
      while (frames_b < 2 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (frames_b < 2) fail_now("b_wait_frame2");
      repeat (5 * 28) @(negedge clk);
      pal_b = 1'b1;

      k = 0;
      while (frames_b < 5 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (frames_b < 5) fail_now("b_wait_frame5");
      done_b = 1'b1;
   end

   // ---------------- completion ----------------
   initial begin
      int k = 0;
      while (!(done_a && done_b) && k < 40000) begin
         @(negedge clk);
         k++;
      end
      if (!(done_a && done_b)) fail_now("global_timeout");
      repeat (4) @(negedge clk);
      check("a_queue_drained", 32'(q_a.size()), 0);
      check("b_queue_drained", 32'(q_b.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
